// File: rtl/code_checker_if.sv
// code_checker_if: controller-side digit/event levels and checker result pulses
interface code_checker_if #(
  parameter int DIGIT_W = 4
);
  logic [DIGIT_W-1:0] digit;
  logic               input_value;
  logic               store_value;
  logic               compare;
  logic               correct_password;
  logic               invalid_password;
  logic               end_sleep;
  logic               locked;
  modport master (
    output digit, input_value, store_value, compare,
    input  correct_password, invalid_password, end_sleep, locked
  );
  modport slave (
    input  digit, input_value, store_value, compare,
    output correct_password, invalid_password, end_sleep, locked
  );
endinterface

// File: rtl/code_checker.sv
// code_checker: password capture/compare datapath with post-failure lockout timer
module code_checker #(
  parameter int                              DIGIT_W      = 4,
  parameter int                              NUM_DIGITS   = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]   DEFAULT_CODE = 16'h1234,
  parameter int                              MAX_ATTEMPTS = 1,
  parameter int                              SLEEP_CYCLES = 50_000_000
) (
  input  logic           clk,
  input  logic           system_reset,
  code_checker_if.slave  bus
);
  localparam int CW = NUM_DIGITS * DIGIT_W;
  localparam int NW = $clog2(NUM_DIGITS + 1);
  localparam int FW = $clog2(MAX_ATTEMPTS + 1);
  localparam int TW = $clog2(SLEEP_CYCLES);
  typedef enum logic [1:0] {IDLE, CHECK, LOCK} state_t;
  state_t          state_q, state_d;
  logic            iv_q, sv_q, cmp_q;
  logic [CW-1:0]   ent_q, ent_d, stg_q, stg_d, pwd_q, pwd_d;
  logic [NW-1:0]   ent_n_q, ent_n_d, stg_n_q, stg_n_d;
  logic [FW-1:0]   fails_q, fails_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ok_q, ok_d, bad_q, bad_d, end_q, end_d;
  logic            iv_e, sv_e, cmp_e, match, lock, stg_full;
  logic [FW-1:0]   fail_inc;
  logic [CW-1:0]   stg_shift;
  assign iv_e      = bus.input_value & ~iv_q;
  assign sv_e      = bus.store_value & ~sv_q;
  assign cmp_e     = bus.compare & ~cmp_q;
  assign match     = (ent_n_q == NW'(NUM_DIGITS)) && (ent_q == pwd_q);
  assign fail_inc  = fails_q + FW'(1);
  assign lock      = !match && (fail_inc == FW'(MAX_ATTEMPTS));
  assign stg_shift = {stg_q[CW-DIGIT_W-1:0], bus.digit};
  assign stg_full  = stg_n_q == NW'(NUM_DIGITS - 1);
  always_comb begin
    state_d = state_q;
    ent_d   = ent_q;
    ent_n_d = ent_n_q;
    stg_d   = stg_q;
    stg_n_d = stg_n_q;
    pwd_d   = pwd_q;
    fails_d = fails_q;
    timer_d = timer_q;
    ok_d    = 1'b0;
    bad_d   = 1'b0;
    if (state_q == IDLE) begin
      if (cmp_e) begin
        state_d = CHECK;
        stg_n_d = '0;
      end else if (iv_e) begin
        ent_d   = {ent_q[CW-DIGIT_W-1:0], bus.digit};
        ent_n_d = (ent_n_q == NW'(NUM_DIGITS)) ? ent_n_q : ent_n_q + NW'(1);
      end else if (sv_e) begin
        stg_d   = stg_shift;
        stg_n_d = stg_full ? '0 : stg_n_q + NW'(1);
        pwd_d   = stg_full ? stg_shift : pwd_q;
      end
    end else if (state_q == CHECK) begin
      ok_d    = match;
      bad_d   = !match;
      ent_d   = '0;
      ent_n_d = '0;
      fails_d = match ? '0 : fail_inc;
      state_d = lock ? LOCK : IDLE;
      timer_d = lock ? TW'(SLEEP_CYCLES - 1) : timer_q;
    end else begin
      state_d = (timer_q == '0) ? IDLE : LOCK;
      timer_d = (timer_q == '0) ? timer_q : timer_q - TW'(1);
      fails_d = (timer_q == '0) ? '0 : fails_q;
    end
    end_d = (state_d == LOCK) && (timer_d == '0);
  end
  always_ff @(posedge clk) begin
    if (system_reset) begin
      state_q <= IDLE;
      iv_q    <= 1'b0;
      sv_q    <= 1'b0;
      cmp_q   <= 1'b0;
      ent_q   <= '0;
      ent_n_q <= '0;
      stg_q   <= '0;
      stg_n_q <= '0;
      pwd_q   <= DEFAULT_CODE;
      fails_q <= '0;
      timer_q <= '0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iv_q    <= bus.input_value;
      sv_q    <= bus.store_value;
      cmp_q   <= bus.compare;
      ent_q   <= ent_d;
      ent_n_q <= ent_n_d;
      stg_q   <= stg_d;
      stg_n_q <= stg_n_d;
      pwd_q   <= pwd_d;
      fails_q <= fails_d;
      timer_q <= timer_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
      end_q   <= end_d;
    end
  end
  assign bus.correct_password = ok_q;
  assign bus.invalid_password = bad_q;
  assign bus.end_sleep        = end_q;
  assign bus.locked           = state_q == LOCK;
endmodule

// File: tb/tb_code_checker.sv
// tb_code_checker: randomized scoreboard bench for code_checker against a digit-queue model
module tb_code_checker;
  localparam int N     = 4;
  localparam int SLEEP = 8;
  localparam int MAX   = 1;
  localparam logic [15:0] DEF = 16'h1234;
  typedef struct {int kind; int cyc; int lk;} exp_t;
  logic clk = 1'b0;
  logic system_reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lock_cnt = 0;
  exp_t q[$];
  int   pwd[N];
  int   ent[$];
  int   stg[$];
  int   fails;
  code_checker_if #(.DIGIT_W(4)) bus();
  code_checker #(
    .DIGIT_W(4), .NUM_DIGITS(N), .DEFAULT_CODE(DEF),
    .MAX_ATTEMPTS(MAX), .SLEEP_CYCLES(SLEEP)
  ) dut (
    .clk(clk), .system_reset(system_reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic take(int kind);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_pulse_kind", kind, -1);
    end else begin
      e = q.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_cycle", cyc, e.cyc);
      if (kind == 1) chk("locked_with_invalid", int'(bus.locked), e.lk);
      if (kind == 2) chk("lock_length", lock_cnt, SLEEP);
    end
  endtask
  always @(negedge clk) begin
    if (system_reset) begin
      lock_cnt = 0;
    end else begin
      lock_cnt = bus.locked ? lock_cnt + 1 : 0;
      if (bus.correct_password && bus.invalid_password) chk("both_pulses", 1, 0);
      if (bus.correct_password) take(0);
      if (bus.invalid_password) take(1);
      if (bus.end_sleep) take(2);
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) pwd[i] = int'(DEF[4*(N-1-i) +: 4]);
    ent.delete();
    stg.delete();
    fails = 0;
  endtask
  function automatic bit model_match();
    if (ent.size() != N) return 1'b0;
    for (int i = 0; i < N; i++) if (ent[i] != pwd[i]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic enter(int d, int hold);
    bus.digit = 4'(d);
    bus.input_value = 1'b1;
    tick(hold);
    bus.input_value = 1'b0;
    tick(1);
    ent.push_back(d);
    if (ent.size() > N) void'(ent.pop_front());
  endtask
  task automatic store(int d, int hold);
    bus.digit = 4'(d);
    bus.store_value = 1'b1;
    tick(hold);
    bus.store_value = 1'b0;
    tick(1);
    stg.push_back(d);
    if (stg.size() == N) begin
      for (int i = 0; i < N; i++) pwd[i] = stg[i];
      stg.delete();
    end
  endtask
  task automatic wait_unlock();
    int b = 0;
    while (bus.locked && b < 40) begin
      tick(1);
      b++;
    end
    chk("unlock_timeout", int'(bus.locked), 0);
    tick(1);
  endtask
  // mode: 0 plain, 1 poke edges during lockout, 2 reset mid-lockout, 3 simultaneous digit edge
  task automatic cmp(int mode);
    bit m;
    bit lk = 1'b0;
    int c = cyc;
    m = model_match();
    ent.delete();
    stg.delete();
    if (m) begin
      fails = 0;
      q.push_back(exp_t'{kind: 0, cyc: c + 2, lk: 0});
    end else begin
      fails++;
      lk = fails >= MAX;
      q.push_back(exp_t'{kind: 1, cyc: c + 2, lk: int'(lk)});
      if (lk && mode != 2) q.push_back(exp_t'{kind: 2, cyc: c + 1 + SLEEP, lk: 1});
      if (lk) fails = 0;
    end
    bus.digit = 4'($urandom_range(0, 15));
    bus.compare = 1'b1;
    if (mode == 3) bus.input_value = 1'b1;
    tick(1);
    bus.compare = 1'b0;
    bus.input_value = 1'b0;
    tick(2);
    if (lk) begin
      if (mode == 1) begin
        bus.compare = 1'b1;
        bus.input_value = 1'b1;
        bus.store_value = 1'b1;
        tick(1);
        bus.compare = 1'b0;
        bus.input_value = 1'b0;
        bus.store_value = 1'b0;
        tick(1);
      end
      if (mode == 2) begin
        system_reset = 1'b1;
        tick(1);
        chk("rst_mid_lock_locked", int'(bus.locked), 0);
        chk("rst_mid_lock_end_sleep", int'(bus.end_sleep), 0);
        system_reset = 1'b0;
        q.delete();
        model_reset();
      end else begin
        wait_unlock();
      end
    end
  endtask
  task automatic enter_code(int d0, int d1, int d2, int d3);
    enter(d0, 3);
    enter(d1, 3);
    enter(d2, 3);
    enter(d3, 3);
  endtask
  initial begin
    int r;
    system_reset = 1'b1;
    bus.digit = '0;
    bus.input_value = 1'b0;
    bus.store_value = 1'b0;
    bus.compare = 1'b0;
    model_reset();
    tick(2);
    chk("rst_correct", int'(bus.correct_password), 0);
    chk("rst_invalid", int'(bus.invalid_password), 0);
    chk("rst_end_sleep", int'(bus.end_sleep), 0);
    chk("rst_locked", int'(bus.locked), 0);
    system_reset = 1'b0;
    tick(1);
    enter_code(1, 2, 3, 4);
    cmp(0);
    enter_code(1, 2, 3, 5);
    cmp(1);
    for (int i = 0; i < N; i++) store(9 - i, 2);
    enter_code(1, 2, 3, 4);
    cmp(0);
    enter_code(9, 8, 7, 6);
    cmp(0);
    store(5, 1);
    store(5, 1);
    enter_code(9, 8, 7, 6);
    cmp(0);
    enter(1, 1);
    enter(2, 1);
    enter(3, 1);
    cmp(0);
    enter(7, 2);
    enter_code(9, 8, 7, 6);
    cmp(0);
    enter(9, 20);
    enter(8, 1);
    enter(7, 1);
    enter(6, 1);
    cmp(0);
    enter_code(9, 8, 7, 6);
    cmp(3);
    for (int i = 0; i < N; i++) store(1, 1);
    enter_code(2, 2, 2, 2);
    cmp(2);
    enter_code(1, 2, 3, 4);
    cmp(0);
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) enter($urandom_range(0, 15), $urandom_range(1, 3));
      else if (r == 4) store($urandom_range(0, 15), $urandom_range(1, 3));
      else if (r <= 6) begin
        for (int i = 0; i < N; i++) enter(pwd[i], $urandom_range(1, 3));
        cmp(0);
      end else if (r == 7) cmp($urandom_range(0, 1));
      else if (r == 8) begin
        for (int i = 0; i < N; i++) store($urandom_range(0, 15), $urandom_range(1, 2));
      end else begin
        repeat ($urandom_range(1, 5)) enter($urandom_range(0, 15), 1);
        cmp($urandom_range(0, 1) == 1 ? 3 : 0);
      end
    end
    tick(20);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
